sv_chan_arb: RTL
================

SV_CHAN_ARB -- requirements
Module: sv_chan_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per channel (legal 1..64).
REQ-003 SHALL have parameter MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL define CH_W = max(1, clog2(NUM_CH)) for channel-index width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
REQ-008 in_data  input  NUM_CH*DATA_W  payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_ready  output  NUM_CH  per-channel accept, combinational, at most one bit high.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  DATA_W  registered payload.
REQ-012 out_chan  output  CH_W  source channel of out_data.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-015 Input handshake for channel i SHALL occur in a cycle with in_valid[i] && in_ready[i]; output handshake SHALL occur in a cycle with out_valid && out_ready.
REQ-016 load_en SHALL be (!out_valid) || out_ready; in_ready SHALL be all-zero when load_en is 0.
REQ-017 When load_en is 1 and any in_valid bit is set, exactly one in_ready bit (the grant) SHALL be 1; otherwise in_ready SHALL be 0.
REQ-018 MODE 0: grant SHALL go to the first requesting channel searching ptr+1, ptr+2, ... wrapping modulo NUM_CH, ending at ptr itself.
REQ-019 MODE 0: ptr SHALL update to the granted index only on an input handshake; otherwise ptr holds.
REQ-020 MODE 1: grant SHALL go to the lowest-indexed requesting channel; ptr is unused and held at reset value.
REQ-021 On an input handshake, out_data/out_chan SHALL load the granted payload/index and out_valid SHALL be 1 next cycle (latency 1).
REQ-022 On an output handshake with no simultaneous input handshake, out_valid SHALL clear next cycle; out_data/out_chan hold.
REQ-023 Simultaneous output and input handshake SHALL replace the word with no bubble (one transfer per cycle sustained).
REQ-024 While out_valid && !out_ready, out_data and out_chan SHALL remain stable.
REQ-025 xfer_cnt SHALL increment by 1 per output handshake and saturate at 0xFFFF.
REQ-026 NUM_CH=1 SHALL degenerate to a 1-entry pipeline register; out_chan constant 0.
REQ-027 Grant SHALL depend only on in_valid, ptr, MODE and load_en, never on in_data.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_data=0, out_chan=0, xfer_cnt=0, ptr=NUM_CH-1 (channel 0 first after reset).
REQ-029 in_ready SHALL be 0 while rst_n is low; a word held mid-transfer at reset SHALL be discarded.
REQ-030 Deassertion SHALL take effect on the first rising clk after rst_n rises; no handshake occurs in the deassertion cycle's preceding half-period.

Verification
REQ-031 MODE 0, NUM_CH=4, in_valid=4'b1111 constant, out_ready=1 -> out_chan sequence 0,1,2,3,0,... one per cycle, xfer_cnt +1 per cycle.
REQ-032 MODE 1, in_valid=4'b1010 constant, out_ready=1 -> out_chan always 1; channel 3 never granted.
REQ-033 Single word ch2 data 0xA5, out_ready=0 for 5 cycles -> out_valid high, out_data=0xA5, out_chan=2 stable; in_ready=0 throughout; one handshake when out_ready rises.
REQ-034 MODE 0, only ch3 requests after reset -> grant ch3; then ch0 and ch3 request -> ch0 granted next (wrap from ptr=3).
REQ-035 Force 65536 output handshakes -> xfer_cnt reaches 0xFFFF and holds at 0xFFFF after further transfers.
REQ-036 Assert rst_n low while out_valid=1 and in_valid set -> out_valid, xfer_cnt, in_ready go 0 immediately without clk; after release first grant is channel 0 when all request.

Source files
------------

// File: rtl/sv_chan_arb.sv
// N-to-1 channel arbiter feeding a single registered output stage.
// Supports round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
module sv_chan_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  input  logic                     out_ready,
  output logic [15:0]              xfer_cnt
);

  // Handshakes: a transfer happens on any cycle where valid && ready are both
  // high at the rising edge. Valid never waits on ready; in_ready is
  // combinational and one-hot (or zero) and never depends on in_data.

  logic [CH_W-1:0]   ptr;
  logic              load_en;
  logic              found;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant_vec;
  logic [DATA_W-1:0] grant_data;
  logic              in_hs;
  logic              out_hs;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    int idx;
    idx        = 0;
    found      = 1'b0;
    grant_idx  = '0;
    grant_vec  = '0;
    grant_data = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      // Fixed priority scans 0..N-1; round-robin scans ptr+1 .. ptr (wrapping).
      if (MODE == 1) idx = k - 1;
      else           idx = (int'(ptr) + k) % NUM_CH;
      if (!found && in_valid[idx]) begin
        found           = 1'b1;
        grant_idx       = CH_W'(idx);
        grant_vec[idx]  = 1'b1;
        grant_data      = in_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  // Gated by rst_n so no channel sees an accept while reset is held.
  assign in_ready = (found && load_en && rst_n) ? grant_vec : '0;
  assign in_hs    = |(in_valid & in_ready);
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      xfer_cnt  <= '0;
      ptr       <= CH_W'(NUM_CH - 1);
    end else begin
      if (in_hs) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        if (MODE == 0) ptr <= grant_idx;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs && (xfer_cnt != 16'hFFFF)) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
